// File: rtl/gray_count_sched.sv
// rtl/gray_count_sched.sv - burst sequencer for an external Gray-code counter
//
// Purpose:
//   Accepts burst commands on a valid/ready handshake. It can clear the
//   external counter first. It then holds the count enable for exactly the
//   commanded number of cycles and pulses done at the end. An optional
//   checker watches the counter output for illegal Gray transitions.
//
// Configuration macro:
//   GRAY_SEQ_CHECK_EN - when defined, the on-line Gray sequence checker is
//                       built. When undefined, err is tied low and gray_in is
//                       unused. FSM timing is the same in both builds.
//
// Ports:
//   clk        clock; all state updates on the rising edge
//   rstn       asynchronous active-low reset
//   cmd_valid  command offered
//   cmd_ready  command can be accepted (high only in IDLE)
//   cmd_len    number of count steps to issue (0 is legal)
//   cmd_clr    clear the counter before stepping
//   abort      terminate the current burst (honoured in CLEAR/RUN)
//   cnt_clr    synchronous clear request to the counter
//   cnt_en     count enable to the counter
//   gray_in    counter output, monitored by the checker
//   busy       burst in progress (CLEAR, RUN, DRAIN)
//   done       one-cycle completion pulse
//   aborted    qualifies done: the burst was ended by abort
//   step_cnt   steps issued in the current/last burst
//   err        sticky Gray sequence violation
module gray_count_sched #(
    parameter int WIDTH = 4,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             cmd_clr,
    input  logic             abort,
    output logic             cnt_clr,
    output logic             cnt_en,
    input  logic [WIDTH-1:0] gray_in,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [LEN_W-1:0] step_cnt,
    output logic             err
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    localparam logic [LEN_W-1:0] LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};
    localparam logic [LEN_W-1:0] LEN_ZERO = '0;

    state_e           state_q, state_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic [LEN_W-1:0] step_q, step_d;
    logic             aborted_q, aborted_d;
    logic             cmd_ready_q;
    logic             cnt_clr_q;
    logic             cnt_en_q;
    logic             busy_q;
    logic             done_q;

    // Next-state and datapath update
    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        step_d    = step_q;
        aborted_d = aborted_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    rem_d     = cmd_len;
                    step_d    = LEN_ZERO;
                    aborted_d = 1'b0;
                    if (cmd_clr) begin
                        state_d = S_CLEAR;
                    end else if (cmd_len != LEN_ZERO) begin
                        state_d = S_RUN;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_CLEAR: begin
                if (abort) begin
                    state_d   = S_DRAIN;
                    aborted_d = 1'b1;
                end else if (rem_q != LEN_ZERO) begin
                    state_d = S_RUN;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_RUN: begin
                // The enable is already high this cycle, so this step counts
                // as issued even if abort is sampled at the same edge.
                step_d = step_q + LEN_ONE;
                rem_d  = rem_q - LEN_ONE;
                if (rem_q == LEN_ONE) begin
                    // The final step wins over a coincident abort.
                    state_d = S_DRAIN;
                end else if (abort) begin
                    state_d   = S_DRAIN;
                    aborted_d = 1'b1;
                end
            end
            S_DRAIN: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and registered outputs. The outputs decode the next state, so
    // each output is high during exactly the cycles spent in its state.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            rem_q       <= LEN_ZERO;
            step_q      <= LEN_ZERO;
            aborted_q   <= 1'b0;
            cmd_ready_q <= 1'b1;
            cnt_clr_q   <= 1'b0;
            cnt_en_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            step_q      <= step_d;
            aborted_q   <= aborted_d;
            cmd_ready_q <= (state_d == S_IDLE);
            cnt_clr_q   <= (state_d == S_CLEAR);
            cnt_en_q    <= (state_d == S_RUN);
            busy_q      <= (state_d == S_CLEAR) || (state_d == S_RUN) ||
                           (state_d == S_DRAIN);
            done_q      <= (state_d == S_DONE);
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign cnt_clr   = cnt_clr_q;
    assign cnt_en    = cnt_en_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign aborted   = aborted_q;
    assign step_cnt  = step_q;

`ifdef GRAY_SEQ_CHECK_EN
    // The counter updates on the edge where it sees cnt_en/cnt_clr. Its new
    // value is therefore judged against the command delayed by one cycle.
    logic [WIDTH-1:0] gray_prev_q;
    logic             en_d_q;
    logic             clr_d_q;
    logic             seen_q;
    logic             err_q;
    logic             bad;

    always_comb begin
        bad = 1'b0;
        if (seen_q) begin
            if (clr_d_q) begin
                bad = (gray_in != '0);
            end else if (en_d_q) begin
                bad = ($countones(gray_in ^ gray_prev_q) != 1);
            end else begin
                bad = (gray_in != gray_prev_q);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            gray_prev_q <= '0;
            en_d_q      <= 1'b0;
            clr_d_q     <= 1'b0;
            seen_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            gray_prev_q <= gray_in;
            en_d_q      <= cnt_en_q;
            clr_d_q     <= cnt_clr_q;
            seen_q      <= 1'b1;
            err_q       <= err_q | bad;
        end
    end

    assign err = err_q;
`else
    logic unused_gray_in;
    assign unused_gray_in = ^gray_in;
    assign err            = 1'b0;
`endif

endmodule

// File: tb/tb_gray_count_sched.sv
// tb/tb_gray_count_sched.sv - directed self-checking bench for gray_count_sched
module tb_gray_count_sched;

    localparam int WIDTH = 4;
    localparam int LEN_W = 8;

`ifdef GRAY_SEQ_CHECK_EN
    localparam logic EXP_FAULT_ERR = 1'b1;
`else
    localparam logic EXP_FAULT_ERR = 1'b0;
`endif

    logic             clk       = 1'b0;
    logic             rstn      = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             cmd_clr   = 1'b0;
    logic             abort     = 1'b0;
    logic [LEN_W-1:0] cmd_len   = '0;
    logic             cmd_ready;
    logic             cnt_clr;
    logic             cnt_en;
    logic [WIDTH-1:0] gray_in;
    logic             busy;
    logic             done;
    logic             aborted;
    logic [LEN_W-1:0] step_cnt;
    logic             err;

    int errors = 0;
    int checks = 0;

    // Counter model; fault_en forces an illegal 0x1 -> 0x2 Gray jump.
    logic [WIDTH-1:0] bin_q;
    logic             fault_en = 1'b0;
    logic [WIDTH-1:0] last_gray = '0;
    logic             saw_wrap  = 1'b0;

    gray_count_sched #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_len   (cmd_len),
        .cmd_clr   (cmd_clr),
        .abort     (abort),
        .cnt_clr   (cnt_clr),
        .cnt_en    (cnt_en),
        .gray_in   (gray_in),
        .busy      (busy),
        .done      (done),
        .aborted   (aborted),
        .step_cnt  (step_cnt),
        .err       (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bin_q <= '0;
        end else if (cnt_clr) begin
            bin_q <= '0;
        end else if (cnt_en) begin
            bin_q <= (fault_en && bin_q == 4'd1) ? 4'd3 : bin_q + 4'd1;
        end
    end

    assign gray_in = bin_q ^ (bin_q >> 1);

    always @(negedge clk) begin
        if (last_gray == 4'h8 && gray_in == 4'h0) saw_wrap = 1'b1;
        last_gray = gray_in;
    end

    // Issue one command and observe it until done; lat=-1 means no done seen.
    task automatic do_burst(input logic [LEN_W-1:0] len, input logic clr, input int abort_at,
                            output int lat, output int en_n, output int clr_n);
        int run_n;
        lat = -1; en_n = 0; clr_n = 0; run_n = 0;
        @(negedge clk);
        for (int w = 0; w < 50 && !cmd_ready; w++) @(negedge clk);
        cmd_len = len; cmd_clr = clr; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int n = 1; n <= 600; n++) begin
            if (n > 1) @(negedge clk);
            abort = 1'b0;
            en_n  += int'(cnt_en);
            clr_n += int'(cnt_clr);
            if (cnt_en) begin
                run_n++;
                if (run_n == abort_at) abort = 1'b1;
            end
            if (done) begin
                lat = n;
                break;
            end
        end
        abort = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready); end
        checks++; if (cnt_clr !== 1'b0) begin errors++; $display("FAIL reset_cnt_clr got=%b exp=0", cnt_clr); end
        checks++; if (cnt_en !== 1'b0) begin errors++; $display("FAIL reset_cnt_en got=%b exp=0", cnt_en); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (aborted !== 1'b0) begin errors++; $display("FAIL reset_aborted got=%b exp=0", aborted); end
        checks++; if (step_cnt !== 8'd0) begin errors++; $display("FAIL reset_step_cnt got=%0d exp=0", step_cnt); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", err); end
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL post_reset_idle got ready=%b busy=%b exp ready=1 busy=0", cmd_ready, busy); end
    endtask

    task automatic test_clear_burst16();
        int lat, en_n, clr_n;
        saw_wrap = 1'b0;
        do_burst(8'd16, 1'b1, 0, lat, en_n, clr_n);
        checks++; if (clr_n != 1) begin errors++; $display("FAIL b16_clr_cycles got=%0d exp=1", clr_n); end
        checks++; if (en_n != 16) begin errors++; $display("FAIL b16_en_cycles got=%0d exp=16", en_n); end
        checks++; if (lat != 19) begin errors++; $display("FAIL b16_latency got=%0d exp=19", lat); end
        checks++; if (step_cnt !== 8'd16) begin errors++; $display("FAIL b16_step_cnt got=%0d exp=16", step_cnt); end
        checks++; if (aborted !== 1'b0) begin errors++; $display("FAIL b16_aborted got=%b exp=0", aborted); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL b16_err got=%b exp=0", err); end
        checks++; if (saw_wrap !== 1'b1 || gray_in !== 4'h0) begin errors++; $display("FAIL b16_wrap got wrap=%b gray=%h exp wrap=1 gray=0", saw_wrap, gray_in); end
        @(negedge clk);
        checks++; if (done !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL b16_after_done got done=%b ready=%b exp done=0 ready=1", done, cmd_ready); end
    endtask

    task automatic test_zero_len();
        int lat, en_n, clr_n;
        do_burst(8'd0, 1'b0, 0, lat, en_n, clr_n);
        checks++; if (lat != 1) begin errors++; $display("FAIL zero_latency got=%0d exp=1", lat); end
        checks++; if (en_n != 0) begin errors++; $display("FAIL zero_en_cycles got=%0d exp=0", en_n); end
        checks++; if (step_cnt !== 8'd0) begin errors++; $display("FAIL zero_step_cnt got=%0d exp=0", step_cnt); end
        do_burst(8'd0, 1'b1, 0, lat, en_n, clr_n);
        checks++; if (lat != 3) begin errors++; $display("FAIL zero_clr_latency got=%0d exp=3", lat); end
        checks++; if (clr_n != 1 || en_n != 0) begin errors++; $display("FAIL zero_clr_enables got clr=%0d en=%0d exp clr=1 en=0", clr_n, en_n); end
    endtask

    task automatic test_abort();
        int lat, en_n, clr_n;
        do_burst(8'd10, 1'b0, 4, lat, en_n, clr_n);
        checks++; if (en_n != 4) begin errors++; $display("FAIL abort_en_cycles got=%0d exp=4", en_n); end
        checks++; if (lat != 6) begin errors++; $display("FAIL abort_latency got=%0d exp=6", lat); end
        checks++; if (aborted !== 1'b1) begin errors++; $display("FAIL abort_aborted got=%b exp=1", aborted); end
        checks++; if (step_cnt !== 8'd4) begin errors++; $display("FAIL abort_step_cnt got=%0d exp=4", step_cnt); end
        // abort coinciding with the last RUN cycle completes normally
        do_burst(8'd3, 1'b0, 3, lat, en_n, clr_n);
        checks++; if (aborted !== 1'b0) begin errors++; $display("FAIL abort_last_aborted got=%b exp=0", aborted); end
        checks++; if (step_cnt !== 8'd3 || en_n != 3) begin errors++; $display("FAIL abort_last_steps got step=%0d en=%0d exp 3/3", step_cnt, en_n); end
        checks++; if (lat != 5) begin errors++; $display("FAIL abort_last_latency got=%0d exp=5", lat); end
    endtask

    task automatic test_max_len();
        int lat, en_n, clr_n;
        do_burst(8'd255, 1'b0, 0, lat, en_n, clr_n);
        checks++; if (lat != 257) begin errors++; $display("FAIL max_latency got=%0d exp=257", lat); end
        checks++; if (en_n != 255 || step_cnt !== 8'd255) begin errors++; $display("FAIL max_steps got en=%0d step=%0d exp 255/255", en_n, step_cnt); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL max_err got=%b exp=0", err); end
    endtask

    task automatic test_fault();
        int lat, en_n, clr_n;
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL fault_pre_err got=%b exp=0", err); end
        fault_en = 1'b1;
        do_burst(8'd4, 1'b1, 0, lat, en_n, clr_n);
        fault_en = 1'b0;
        checks++; if (err !== EXP_FAULT_ERR) begin errors++; $display("FAIL fault_err got=%b exp=%b", err, EXP_FAULT_ERR); end
        do_burst(8'd2, 1'b1, 0, lat, en_n, clr_n);
        checks++; if (err !== EXP_FAULT_ERR) begin errors++; $display("FAIL fault_sticky got=%b exp=%b", err, EXP_FAULT_ERR); end
        checks++; if (lat != 5) begin errors++; $display("FAIL fault_clean_latency got=%0d exp=5", lat); end
    endtask

    task automatic test_back_to_back();
        int bad, dones, first_done, ready_after;
        bad = 0; dones = 0; first_done = -1; ready_after = -1;
        @(negedge clk);
        cmd_len = 8'd3; cmd_clr = 1'b0; cmd_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy && cmd_ready) bad++;
            if (first_done >= 0 && i == first_done + 1) ready_after = int'(cmd_ready);
            if (done) begin
                dones++;
                if (first_done < 0) first_done = i;
            end
        end
        cmd_valid = 1'b0;
        for (int i = 0; i < 20 && !done; i++) @(negedge clk);
        checks++; if (bad != 0) begin errors++; $display("FAIL b2b_ready_while_busy got=%0d exp=0", bad); end
        checks++; if (first_done != 4) begin errors++; $display("FAIL b2b_first_done got=%0d exp=4", first_done); end
        checks++; if (ready_after != 1) begin errors++; $display("FAIL b2b_ready_after_done got=%0d exp=1", ready_after); end
        checks++; if (dones != 3) begin errors++; $display("FAIL b2b_done_count got=%0d exp=3", dones); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        int dones, ens;
        dones = 0; ens = 0;
        @(negedge clk);
        cmd_len = 8'd20; cmd_clr = 1'b0; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (cnt_en !== 1'b1) begin errors++; $display("FAIL rst_mid_in_run got=%b exp=1", cnt_en); end
        #2 rstn = 1'b0;
        #1;
        checks++; if (cnt_en !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rst_mid_async got en=%b busy=%b exp 0/0", cnt_en, busy); end
        checks++; if (cmd_ready !== 1'b1 || step_cnt !== 8'd0) begin errors++; $display("FAIL rst_mid_ready_step got ready=%b step=%0d exp 1/0", cmd_ready, step_cnt); end
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            dones += int'(done);
            ens   += int'(cnt_en);
        end
        checks++; if (dones != 0 || ens != 0) begin errors++; $display("FAIL rst_mid_no_done got done=%0d en=%0d exp 0/0", dones, ens); end
    endtask

    initial begin
        test_reset();
        test_clear_burst16();
        test_zero_len();
        test_abort();
        test_max_len();
        test_fault();
        test_back_to_back();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
